// File: rtl/led_pkg.sv
// Shared types and default timing for the LED pulse stretcher.
package led_pkg;

  // Per-channel flash state; 2'd3 is unused and falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } led_state_t;

  // Board defaults: 1 ms sample tick at 125 MHz, 50 ms flash, 25 ms dark gap.
  localparam int DEF_WIDTH            = 4;
  localparam int DEF_SAMPLE_COUNT_MAX = 125000;
  localparam int DEF_ON_COUNT         = 50;
  localparam int DEF_OFF_COUNT        = 25;
  localparam int DEF_PEND_W           = 2;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every SAMPLE_COUNT_MAX clocks.
module sample_tick_gen
  import led_pkg::*;
#(
  parameter int SAMPLE_COUNT_MAX = DEF_SAMPLE_COUNT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (SAMPLE_COUNT_MAX > 1) ? $clog2(SAMPLE_COUNT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_COUNT_MAX - 1);

  logic [CW-1:0] cnt_r;
  logic          at_last_s;

  // The tick is high for exactly the cycle in which the counter sits on its last value.
  assign at_last_s = (cnt_r == LAST);
  assign tick      = at_last_s;

  // Count 0..SAMPLE_COUNT_MAX-1 and wrap; a divide-by-one stays at zero and ticks every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (at_last_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event pulses into visible LED flashes with a dark gap,
// queueing events that arrive while a channel is busy.
module led_pulse_stretcher
  import led_pkg::*;
#(
  parameter int WIDTH            = DEF_WIDTH,
  parameter int SAMPLE_COUNT_MAX = DEF_SAMPLE_COUNT_MAX,
  parameter int ON_COUNT         = DEF_ON_COUNT,
  parameter int OFF_COUNT        = DEF_OFF_COUNT,
  parameter int PEND_W           = DEF_PEND_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pulse_in,
  input  logic             clr,
  output logic [WIDTH-1:0] led_out,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] overflow
);

  localparam int CNT_MAX = max_int(ON_COUNT, OFF_COUNT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_COUNT - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_COUNT - 1);
  localparam logic [PEND_W-1:0] PEND_SAT = {PEND_W{1'b1}};

  logic tick_s;

  sample_tick_gen #(
    .SAMPLE_COUNT_MAX(SAMPLE_COUNT_MAX)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick_s)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    led_state_t        state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [PEND_W-1:0] pend_r, pend_s;
    logic              ovf_r, ovf_s;
    logic              led_r, busy_r;

    // Next-state, phase count, pending queue and sticky overflow for one channel.
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      pend_s  = pend_r;
      ovf_s   = ovf_r;
      if (clr) begin
        state_s = IDLE;
        cnt_s   = '0;
        pend_s  = '0;
        ovf_s   = 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (pulse_in[i]) begin
              state_s = ON;
              cnt_s   = '0;
            end else begin
              state_s = IDLE;
            end
          end
          ON: begin
            if (tick_s) begin
              if (cnt_r == ON_LAST) begin
                state_s = GAP;
                cnt_s   = '0;
              end else begin
                cnt_s = cnt_r + CNT_W'(1);
              end
            end else begin
              cnt_s = cnt_r;
            end
            if (pulse_in[i]) begin
              if (pend_r == PEND_SAT) begin
                ovf_s = 1'b1;
              end else begin
                pend_s = pend_r + PEND_W'(1);
              end
            end else begin
              pend_s = pend_r;
            end
          end
          GAP: begin
            if (tick_s && (cnt_r == OFF_LAST)) begin
              // A new event on the exit edge replaces the dequeue, so pend is untouched.
              cnt_s = '0;
              if (pulse_in[i]) begin
                state_s = ON;
                pend_s  = pend_r;
              end else if (pend_r != '0) begin
                state_s = ON;
                pend_s  = pend_r - PEND_W'(1);
              end else begin
                state_s = IDLE;
              end
            end else begin
              if (tick_s) begin
                cnt_s = cnt_r + CNT_W'(1);
              end else begin
                cnt_s = cnt_r;
              end
              if (pulse_in[i]) begin
                if (pend_r == PEND_SAT) begin
                  ovf_s = 1'b1;
                end else begin
                  pend_s = pend_r + PEND_W'(1);
                end
              end else begin
                pend_s = pend_r;
              end
            end
          end
          default: begin
            state_s = IDLE;
            cnt_s   = '0;
            pend_s  = '0;
          end
        endcase
      end
    end

    // Channel state plus outputs registered from the post-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= IDLE;
        cnt_r   <= '0;
        pend_r  <= '0;
        ovf_r   <= 1'b0;
        led_r   <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
        pend_r  <= pend_s;
        ovf_r   <= ovf_s;
        led_r   <= (state_s == ON);
        busy_r  <= (state_s != IDLE);
      end
    end

    assign led_out[i]  = led_r;
    assign busy[i]     = busy_r;
    assign overflow[i] = ovf_r;
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench: ticks land on edges 10,20,30,... counted from reset release.
module tb_led_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [3:0] pulse_in;
  logic [3:0] led_out;
  logic [3:0] busy;
  logic [3:0] overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         edge_n;
    logic [3:0] pulse;
    logic       clr;
    logic [3:0] exp_led;
    logic [3:0] exp_busy;
    logic [3:0] exp_ovf;
  } vec_t;

  vec_t vecs[$];

  led_pulse_stretcher #(
    .WIDTH(4), .SAMPLE_COUNT_MAX(10), .ON_COUNT(5), .OFF_COUNT(3), .PEND_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .clr(clr),
    .led_out(led_out), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] p, input logic c);
    pulse_in = p;
    clr      = c;
    @(posedge clk);
    #1;
    pulse_in = 4'b0000;
    clr      = 1'b0;
    cyc++;
  endtask

  task automatic add(input int e, input logic [3:0] p, input logic c,
                     input logic [3:0] l, input logic [3:0] b, input logic [3:0] o);
    vec_t v;
    v.edge_n = e; v.pulse = p; v.clr = c; v.exp_led = l; v.exp_busy = b; v.exp_ovf = o;
    vecs.push_back(v);
  endtask

  initial begin
    int hi[4];
    int lanes_bad;

    rst_n    = 1'b0;
    clr      = 1'b0;
    pulse_in = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check4("reset led", led_out, 4'b0000);
    check4("reset busy", busy, 4'b0000);
    check4("reset ovf", overflow, 4'b0000);

    // ch0: single flash. ch1: two queued -> 3 flashes. ch2: five queued -> saturate, 4 flashes.
    // ch3: pulse on ON-exit edge 50 (extra flash) and on GAP-exit edge 160 with pend=0.
    add(1,   4'b1111, 1'b0, 4'b1111, 4'b1111, 4'b0000);
    add(3,   4'b0100, 1'b0, 4'b1111, 4'b1111, 4'b0000);
    add(4,   4'b0100, 1'b0, 4'b1111, 4'b1111, 4'b0000);
    add(5,   4'b0110, 1'b0, 4'b1111, 4'b1111, 4'b0000);
    add(6,   4'b0100, 1'b0, 4'b1111, 4'b1111, 4'b0100);
    add(7,   4'b0100, 1'b0, 4'b1111, 4'b1111, 4'b0100);
    add(8,   4'b0010, 1'b0, 4'b1111, 4'b1111, 4'b0100);
    add(49,  4'b0000, 1'b0, 4'b1111, 4'b1111, 4'b0100);
    add(50,  4'b1000, 1'b0, 4'b0000, 4'b1111, 4'b0100);
    add(79,  4'b0000, 1'b0, 4'b0000, 4'b1111, 4'b0100);
    add(80,  4'b0000, 1'b0, 4'b1110, 4'b1110, 4'b0100);
    add(129, 4'b0000, 1'b0, 4'b1110, 4'b1110, 4'b0100);
    add(130, 4'b0000, 1'b0, 4'b0000, 4'b1110, 4'b0100);
    add(159, 4'b0000, 1'b0, 4'b0000, 4'b1110, 4'b0100);
    add(160, 4'b1000, 1'b0, 4'b1110, 4'b1110, 4'b0100);
    add(209, 4'b0000, 1'b0, 4'b1110, 4'b1110, 4'b0100);
    add(210, 4'b0000, 1'b0, 4'b0000, 4'b1110, 4'b0100);
    add(239, 4'b0000, 1'b0, 4'b0000, 4'b1110, 4'b0100);
    add(240, 4'b0000, 1'b0, 4'b0100, 4'b0100, 4'b0100);
    add(289, 4'b0000, 1'b0, 4'b0100, 4'b0100, 4'b0100);
    add(290, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0100);
    add(319, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0100);
    add(320, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100);
    add(325, 4'b1000, 1'b0, 4'b1000, 4'b1000, 4'b0100);
    add(326, 4'b0000, 1'b0, 4'b1000, 4'b1000, 4'b0100);
    add(327, 4'b1000, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    add(328, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000);

    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    foreach (vecs[k]) begin
      while (cyc < vecs[k].edge_n - 1) step(4'b0000, 1'b0);
      step(vecs[k].pulse, vecs[k].clr);
      check4($sformatf("e%0d led", vecs[k].edge_n), led_out, vecs[k].exp_led);
      check4($sformatf("e%0d busy", vecs[k].edge_n), busy, vecs[k].exp_busy);
      check4($sformatf("e%0d ovf", vecs[k].edge_n), overflow, vecs[k].exp_ovf);
    end

    // Asynchronous reset in the middle of a flash.
    step(4'b0001, 1'b0);
    repeat (3) step(4'b0000, 1'b0);
    check4("preasync led", led_out, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check4("async led", led_out, 4'b0000);
    check4("async busy", busy, 4'b0000);
    check4("async ovf", overflow, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // All channels at once: identical waveforms, 49 lit cycles each.
    for (int c = 0; c < 4; c++) hi[c] = 0;
    lanes_bad = 0;
    step(4'b1111, 1'b0);
    for (int k = 0; k < 100; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (led_out[c] === 1'b1) hi[c]++;
      end
      if (!(led_out === 4'b0000 || led_out === 4'b1111)) lanes_bad++;
      step(4'b0000, 1'b0);
    end
    for (int c = 0; c < 4; c++) check_int($sformatf("all ch%0d lit cycles", c), hi[c], 49);
    check_int("all lanes differ count", lanes_bad, 0);
    check4("all busy end", busy, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
